booth_seq_ctrl: RTL and testbench
=================================

Name: booth_seq_ctrl

Overview:
Parametrised iteration sequencer for radix-2^R Booth multipliers. It generalises the fixed radix-8, free-running control counter. It adds a start/busy/done handshake, an operand-load pulse, a per-step enable with step index, a last-step flag, and a synchronous abort. It sits beside the Booth datapath: the datapath loads operands on load_o, retires R multiplier bits per step_en_o, and the product is valid on done_o.

Parameters:
K, 8, operand width in bits; legal range 2..64.
R, 3, multiplier bits retired per step (radix 2^R); legal range 1..K.
N, (K+R-1)/R, derived step count (ceiling division); localparam, not overridable.
CW, $clog2(N+1), derived step-counter width; localparam.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
start_i  in  1  operation request; sampled only in IDLE
abort_i  in  1  synchronous cancel; returns the block to IDLE
zero_rem_i  in  1  datapath flag: remaining multiplier bits are all sign bits (used only with EARLY_TERM_EN)
busy_o  out  1  high in LOAD, RUN and DONE
load_o  out  1  one-cycle pulse: datapath captures operands and clears the accumulator
step_en_o  out  1  high for each RUN cycle: datapath performs one Booth step
step_idx_o  out  CW  index of the current step, 0..N-1; 0 outside RUN
last_o  out  1  high with step_en_o on step N-1 (or on the early-terminated step)
done_o  out  1  one-cycle pulse: product valid at the datapath output

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, all outputs 0. Reset mid-operation discards the operation; no done_o is issued.
- FSM states: IDLE, LOAD, RUN, DONE. All outputs are decoded from registered state and counter (Moore); no combinational path from inputs to outputs.
- IDLE: when start_i=1, go to LOAD.
- LOAD: load_o=1 for one cycle. Next state is RUN with counter=0.
- RUN: step_en_o=1 and step_idx_o=counter. While counter<N-1, counter increments. When counter==N-1, last_o=1 and next state is DONE.
- DONE: done_o=1 for one cycle. Next state is IDLE and counter returns to 0.
- Latency: start sampled at edge t gives load_o in cycle t+1, steps in cycles t+2..t+N+1, and done_o in cycle t+N+2. Next start is accepted in the done cycle+1.
- start_i outside IDLE is ignored; it is not queued.
- abort_i=1 in any non-IDLE state: next state is IDLE, counter=0, no done_o. abort_i has priority over step advance.
- If abort_i and start_i are both high in IDLE, abort_i wins and the block stays IDLE.
- N=1 (R>=K): a single RUN cycle with step_idx_o=0 and last_o=1.
- The counter never exceeds N-1; there is no wrap-around in RUN.

Optional Feature:
Macro BOOTH_EARLY_TERM_EN.
- Defined: in RUN, if zero_rem_i=1 with counter<N-1, the current step is treated as last. last_o=1, next state is DONE, and the remaining steps are skipped. Latency is shortened accordingly.
- Undefined: zero_rem_i is ignored (port kept for a stable interface) and every operation runs exactly N steps.

Decomposition:
- Package booth_ctrl_pkg holds:
  - the state enum (IDLE/LOAD/RUN/DONE, 2-bit encoding);
  - a function num_steps(K,R) returning ceiling(K/R);
  - a function cnt_width(N).
- Natural sub-module: booth_step_counter. It holds the CW-bit counter with clear, enable and terminal-count output (cnt==N-1), and is shared by future Booth and SRT sequencers.

Test Plan:
- K=8, R=3 (N=3), start_i pulse at cycle 0 -> load_o at 1; step_en_o at 2,3,4 with step_idx_o 0,1,2; last_o at 4; done_o at 5; busy_o high 1..5.
- K=16, R=2 (N=8), start held high continuously -> done_o every 11 cycles; step_idx_o runs 0..7 each operation; no start is missed or double-counted.
- K=8, R=3, start_i pulsed again at cycles 2 and 4 -> ignored; exactly one done_o at 5.
- K=8, R=1 (N=8), abort_i at step_idx_o=4 -> IDLE next cycle; no done_o; new start gives a full 8-step run.
- K=8, R=3, rst low at step_idx_o=1 -> all outputs 0 immediately; after release, IDLE until start.
- BOOTH_EARLY_TERM_EN, K=16, R=2, zero_rem_i=1 at step_idx_o=3 -> last_o at that step, done_o next cycle. Same stimulus without the macro -> 8 steps.

Source files
------------

// File: rtl/booth_ctrl_pkg.sv
// Shared types and sizing helpers for the Booth/SRT iteration sequencers.
// Optional early termination is enabled by defining BOOTH_EARLY_TERM_EN.
package booth_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } booth_state_t;

    // Ceiling division: the final step may retire fewer than r real bits.
    function automatic int num_steps(input int k, input int r);
        return (k + r - 1) / r;
    endfunction

    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/booth_step_counter.sv
// Step counter with clear, enable and terminal-count flag (cnt == N-1).
// Saturates at N-1; BOOTH_EARLY_TERM_EN does not affect this block.
module booth_step_counter #(
    parameter int N  = 3,
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // Clear wins over enable so an abort or final step always returns to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/booth_seq_ctrl.sv
// Radix-2^R Booth iteration sequencer: start/busy/done handshake, load pulse, step strobes.
// Define BOOTH_EARLY_TERM_EN to let zero_rem_i end the run before step N-1.
module booth_seq_ctrl
    import booth_ctrl_pkg::*;
#(
    parameter int K = 8,
    parameter int R = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start_i,
    input  logic                                   abort_i,
    input  logic                                   zero_rem_i,
    output logic                                   busy_o,
    output logic                                   load_o,
    output logic                                   step_en_o,
    output logic [cnt_width(num_steps(K, R))-1:0]  step_idx_o,
    output logic                                   last_o,
    output logic                                   done_o
);

    localparam int N  = num_steps(K, R);
    localparam int CW = cnt_width(N);

    booth_state_t  state;
    booth_state_t  state_nxt;
    logic [CW-1:0] cnt;
    logic          tc;
    logic          early;
    logic          last_step;
    logic          cnt_clr;
    logic          cnt_en;

`ifdef BOOTH_EARLY_TERM_EN
    // This is the only input-to-output path, and it exists only in this build.
    assign early = zero_rem_i;
`else
    logic unused_zero_rem;
    assign unused_zero_rem = zero_rem_i;
    assign early           = 1'b0;
`endif

    assign last_step = (state == RUN) && (tc || early);
    assign cnt_clr   = (state != RUN) || abort_i || last_step;
    assign cnt_en    = (state == RUN);

    booth_step_counter #(
        .N  (N),
        .CW (CW)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (cnt),
        .tc  (tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort outranks every other transition, including a start seen in IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (!abort_i && start_i) state_nxt = LOAD;
            LOAD: state_nxt = abort_i ? IDLE : RUN;
            RUN:  begin
                if (abort_i) begin
                    state_nxt = IDLE;
                end else if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o     = (state != IDLE);
        load_o     = (state == LOAD);
        step_en_o  = (state == RUN);
        step_idx_o = (state == RUN) ? cnt : '0;
        last_o     = last_step;
        done_o     = (state == DONE);
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed bench for booth_seq_ctrl over N=3, N=8 (R=2 and R=1) and N=1 configurations.
// Expectations follow BOOTH_EARLY_TERM_EN when the bench is built with it.
module tb_booth_seq_ctrl;

    logic clk;
    logic rst;
    logic start    [4];
    logic abort    [4];
    logic zero_rem [4];
    logic busy     [4];
    logic load     [4];
    logic step     [4];
    logic last     [4];
    logic done     [4];
    logic [1:0] idx_a;
    logic [3:0] idx_b;
    logic [3:0] idx_c;
    logic [0:0] idx_d;

    int total = 0;
    int bad   = 0;
    int done_seen;

    booth_seq_ctrl #(.K(8), .R(3)) dut_a (
        .clk(clk), .rst(rst), .start_i(start[0]), .abort_i(abort[0]), .zero_rem_i(zero_rem[0]),
        .busy_o(busy[0]), .load_o(load[0]), .step_en_o(step[0]), .step_idx_o(idx_a),
        .last_o(last[0]), .done_o(done[0])
    );

    booth_seq_ctrl #(.K(16), .R(2)) dut_b (
        .clk(clk), .rst(rst), .start_i(start[1]), .abort_i(abort[1]), .zero_rem_i(zero_rem[1]),
        .busy_o(busy[1]), .load_o(load[1]), .step_en_o(step[1]), .step_idx_o(idx_b),
        .last_o(last[1]), .done_o(done[1])
    );

    booth_seq_ctrl #(.K(8), .R(1)) dut_c (
        .clk(clk), .rst(rst), .start_i(start[2]), .abort_i(abort[2]), .zero_rem_i(zero_rem[2]),
        .busy_o(busy[2]), .load_o(load[2]), .step_en_o(step[2]), .step_idx_o(idx_c),
        .last_o(last[2]), .done_o(done[2])
    );

    booth_seq_ctrl #(.K(8), .R(8)) dut_d (
        .clk(clk), .rst(rst), .start_i(start[3]), .abort_i(abort[3]), .zero_rem_i(zero_rem[3]),
        .busy_o(busy[3]), .load_o(load[3]), .step_en_o(step[3]), .step_idx_o(idx_d),
        .last_o(last[3]), .done_o(done[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {busy, load, step_en, last, done, step_idx[3:0]}
    function automatic logic [8:0] pk(input logic b, input logic l, input logic s,
                                      input logic la, input logic d, input int ix);
        return {b, l, s, la, d, 4'(ix)};
    endfunction

    function automatic logic [8:0] observe(input int i);
        logic [3:0] ix;
        case (i)
            0:       ix = {2'b00, idx_a};
            1:       ix = idx_b;
            2:       ix = idx_c;
            default: ix = {3'b000, idx_d};
        endcase
        return {busy[i], load[i], step[i], last[i], done[i], ix};
    endfunction

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input int i, input logic [8:0] exp);
        compare(tag, 32'(observe(i)), 32'(exp));
    endtask

    task automatic applyStimulus(input int i, input logic s, input logic a, input logic z);
        start[i]    = s;
        abort[i]    = a;
        zero_rem[i] = z;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(i, 1'b0, 1'b0, 1'b0);
        #3;
        for (int i = 0; i < 4; i++) checkOutput($sformatf("reset_%0d", i), i, '0);
        tick();
        rst = 1'b1;
        tick();

        // N=3 run with start re-pulsed during steps 0 and 2
        $display("[TB] N=3 basic run");
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 1'b0);
        checkOutput("a_load", 0, pk(1, 1, 0, 0, 0, 0));
        tick();
        checkOutput("a_step0", 0, pk(1, 0, 1, 0, 0, 0));
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("a_step1", 0, pk(1, 0, 1, 0, 0, 1));
        applyStimulus(0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("a_step2", 0, pk(1, 0, 1, 1, 0, 2));
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("a_done", 0, pk(1, 0, 0, 0, 1, 0));
        applyStimulus(0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("a_idle1", 0, '0);
        tick();
        checkOutput("a_idle2", 0, '0);

        // N=8 back-to-back with start held: 11-cycle period
        $display("[TB] N=8 start held");
        done_seen = 0;
        applyStimulus(1, 1'b1, 1'b0, 1'b0);
        tick();
        for (int c = 0; c < 22; c++) begin
            int ph;
            logic [8:0] e;
            ph = c % 11;
            if (ph == 0)       e = pk(1, 1, 0, 0, 0, 0);
            else if (ph <= 8)  e = pk(1, 0, 1, ph == 8, 0, ph - 1);
            else if (ph == 9)  e = pk(1, 0, 0, 0, 1, 0);
            else               e = '0;
            if (done[1]) done_seen++;
            checkOutput($sformatf("b_hold_c%0d", c), 1, e);
            if (c == 21) applyStimulus(1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        checkOutput("b_hold_end", 1, '0);
        compare("b_done_count", 32'(done_seen), 32'd2);

        // zero_rem at step 3 on the N=8 instance
        $display("[TB] N=8 zero_rem at step 3");
        applyStimulus(1, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1, 1'b0, 1'b0, 1'b0);
        checkOutput("e_load", 1, pk(1, 1, 0, 0, 0, 0));
        for (int s = 0; s < 3; s++) begin
            tick();
            checkOutput($sformatf("e_step%0d", s), 1, pk(1, 0, 1, 0, 0, s));
        end
        tick();
        applyStimulus(1, 1'b0, 1'b0, 1'b1);
`ifdef BOOTH_EARLY_TERM_EN
        checkOutput("e_step3_last", 1, pk(1, 0, 1, 1, 0, 3));
        tick();
        applyStimulus(1, 1'b0, 1'b0, 1'b0);
        checkOutput("e_done", 1, pk(1, 0, 0, 0, 1, 0));
`else
        checkOutput("e_step3", 1, pk(1, 0, 1, 0, 0, 3));
        applyStimulus(1, 1'b0, 1'b0, 1'b0);
        for (int s = 4; s < 8; s++) begin
            tick();
            checkOutput($sformatf("e_step%0d", s), 1, pk(1, 0, 1, s == 7, 0, s));
        end
        tick();
        checkOutput("e_done", 1, pk(1, 0, 0, 0, 1, 0));
`endif
        tick();
        checkOutput("e_idle", 1, '0);

        // N=8 (R=1) abort at step 4, then abort+start in IDLE, then a full run
        $display("[TB] N=8 abort");
        applyStimulus(2, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(2, 1'b0, 1'b0, 1'b0);
        checkOutput("c_load", 2, pk(1, 1, 0, 0, 0, 0));
        for (int s = 0; s < 5; s++) begin
            tick();
            checkOutput($sformatf("c_step%0d", s), 2, pk(1, 0, 1, 0, 0, s));
        end
        applyStimulus(2, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(2, 1'b0, 1'b0, 1'b0);
        checkOutput("c_abort_idle", 2, '0);
        tick();
        checkOutput("c_no_done", 2, '0);
        applyStimulus(2, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(2, 1'b0, 1'b0, 1'b0);
        checkOutput("c_abort_beats_start", 2, '0);
        applyStimulus(2, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(2, 1'b0, 1'b0, 1'b0);
        checkOutput("c_reload", 2, pk(1, 1, 0, 0, 0, 0));
        for (int s = 0; s < 8; s++) begin
            tick();
            checkOutput($sformatf("c_rerun%0d", s), 2, pk(1, 0, 1, s == 7, 0, s));
        end
        tick();
        checkOutput("c_done", 2, pk(1, 0, 0, 0, 1, 0));
        tick();
        checkOutput("c_idle", 2, '0);

        // Asynchronous reset in the middle of step 1
        $display("[TB] N=3 async reset mid-run");
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("d_step1", 0, pk(1, 0, 1, 0, 0, 1));
        #2;
        rst = 1'b0;
        #1;
        checkOutput("d_rst_async", 0, '0);
        #2;
        rst = 1'b1;
        tick();
        checkOutput("d_idle1", 0, '0);
        tick();
        checkOutput("d_idle2", 0, '0);

        // N=1: one RUN cycle that is both first and last
        $display("[TB] N=1 run");
        applyStimulus(3, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(3, 1'b0, 1'b0, 1'b0);
        checkOutput("n1_load", 3, pk(1, 1, 0, 0, 0, 0));
        tick();
        checkOutput("n1_step", 3, pk(1, 0, 1, 1, 0, 0));
        tick();
        checkOutput("n1_done", 3, pk(1, 0, 0, 0, 1, 0));
        tick();
        checkOutput("n1_idle", 3, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
